// File: rtl/cpu_bus_arbiter_pkg.sv
// cpu_bus_arb_pkg: shared types and constants for the CPU bus arbiter.
//   arb_state_e  - arbiter FSM states (IDLE / ISSUE / WAIT)
//   DEF_ADDR_W   - default address width
//   DEF_DATA_W   - default data width
//   TO_CNT_W     - width of the WAIT timeout counter
package cpu_bus_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int TO_CNT_W   = 8;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// cpu_bus_arbiter_if: external memory bus between the arbiter and the fabric.
//   o_bus_clk        - one-cycle transfer strobe
//   o_bus_we         - transfer is a write
//   o_bus_addr       - transfer address
//   o_bus_data       - write data
//   i_bus_data       - read data returned by the fabric
//   i_bus_data_ready - fabric has completed the transfer
// Modports: master (arbiter side), slave (fabric side).
interface cpu_bus_arbiter_if
    import cpu_bus_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              o_bus_clk;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [DATA_W-1:0] o_bus_data;
    logic [DATA_W-1:0] i_bus_data;
    logic              i_bus_data_ready;

    modport master (
        output o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
        input  i_bus_data, i_bus_data_ready
    );

    modport slave (
        input  o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
        output i_bus_data, i_bus_data_ready
    );
endinterface

// File: rtl/cpu_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    - request vector
//   ptr    - index where the upward scan starts (wraps modulo NUM_REQ)
//   onehot - one-hot winner
//   idx    - winner index
//   valid  - at least one request is set
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      idx,
    output logic               valid
);
    int   k;
    logic found;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        k      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && req[k]) begin
                found     = 1'b1;
                onehot[k] = 1'b1;
                idx       = IW'(k);
            end
        end
    end

    assign valid = |req;
endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: round-robin arbiter sharing one external memory bus
// between NUM_REQ requesters (index 0 is the CPU). One transfer at a time:
// IDLE (arbitrate) -> ISSUE (strobe) -> WAIT (until fabric ready).
//   i_clk, i_rst     - clock, asynchronous active-low reset
//   i_req/i_we       - per-requester request level and write flag
//   i_addr/i_wdata   - packed per-requester attributes (slice k = requester k)
//   o_gnt            - one-hot grant held for the whole transfer
//   o_done           - one-cycle completion pulse to the granted requester
//   o_rdata          - read data, valid in the o_done cycle, held until next read
//   o_err            - abort pulse alongside o_done (timeout build only)
//   o_busy           - FSM not in IDLE
//   bus              - fabric side (cpu_bus_arbiter_if.master)
// Build option: define CPU_BUS_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles; otherwise WAIT blocks until ready and o_err is tied low.
module cpu_bus_arbiter
    import cpu_bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_done,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_err,
    output logic                      o_busy,
    cpu_bus_arbiter_if.master         bus
);
    localparam int IW = $clog2(NUM_REQ);

    arb_state_e        state;
    logic [IW-1:0]     ptr;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req    (i_req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

`ifdef CPU_BUS_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt;
    logic                err_q;
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            o_gnt    <= '0;
            o_done   <= '0;
            o_rdata  <= '0;
            bus_we   <= 1'b0;
            bus_addr <= '0;
            bus_data <= '0;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
            to_cnt   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            o_done <= '0;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        o_gnt    <= pick_onehot;
                        bus_we   <= i_we[pick_idx];
                        bus_addr <= i_addr[pick_idx*ADDR_W +: ADDR_W];
                        bus_data <= i_wdata[pick_idx*DATA_W +: DATA_W];
                        ptr      <= (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Ready is deliberately not sampled during the strobe cycle.
                    state <= S_WAIT;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    // Ready wins over a coincident timeout.
                    if (bus.i_bus_data_ready) begin
                        o_done <= o_gnt;
                        o_gnt  <= '0;
                        if (!bus_we) o_rdata <= bus.i_bus_data;
                        state  <= S_IDLE;
                    end
`ifdef CPU_BUS_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_CNT_W'(TIMEOUT-1)) begin
                        o_done  <= o_gnt;
                        o_gnt   <= '0;
                        err_q   <= 1'b1;
                        o_rdata <= '0;
                        state   <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_busy          = (state != S_IDLE);
    assign bus.o_bus_clk   = (state == S_ISSUE);
    assign bus.o_bus_we    = bus_we;
    assign bus.o_bus_addr  = bus_addr;
    assign bus.o_bus_data  = bus_data;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed scenarios with literal expectations,
// then randomized requesters/fabric, all checked every cycle against a
// transaction-level model (winner, cycles since grant, latched attributes).
module tb_cpu_bus_arbiter;
    import cpu_bus_arb_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 4;
    localparam bit TO_EN   = 1'b1;
`else
    localparam int TIMEOUT = 255;
    localparam bit TO_EN   = 1'b0;
`endif

    logic                      i_clk = 1'b0;
    logic                      i_rst;
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ-1:0]        i_we;
    logic [NUM_REQ*ADDR_W-1:0] i_addr;
    logic [NUM_REQ*DATA_W-1:0] i_wdata;
    logic [NUM_REQ-1:0]        o_gnt;
    logic [NUM_REQ-1:0]        o_done;
    logic [DATA_W-1:0]         o_rdata;
    logic                      o_err;
    logic                      o_busy;

    cpu_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cpu_bus_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .i_we    (i_we),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .o_gnt   (o_gnt),
        .o_done  (o_done),
        .o_rdata (o_rdata),
        .o_err   (o_err),
        .o_busy  (o_busy),
        .bus     (bus.master)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int rr_first(input logic [NUM_REQ-1:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    int                 m_ptr, m_win, m_age;
    bit                 m_active;
    logic [NUM_REQ-1:0] exp_gnt, exp_done;
    logic               exp_err, exp_busy, exp_bclk, exp_we;
    logic [ADDR_W-1:0]  exp_addr;
    logic [DATA_W-1:0]  exp_wdata, exp_rdata;

    always @(negedge i_clk) begin
        int w;
        if (!i_rst) begin
            m_ptr = 0; m_win = 0; m_age = 0; m_active = 0;
            exp_gnt = '0; exp_done = '0; exp_err = 0; exp_busy = 0; exp_bclk = 0;
            exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        end
        chk("m_gnt",   64'(o_gnt),          64'(exp_gnt));
        chk("m_done",  64'(o_done),         64'(exp_done));
        chk("m_err",   64'(o_err),          64'(exp_err));
        chk("m_busy",  64'(o_busy),         64'(exp_busy));
        chk("m_rdata", 64'(o_rdata),        64'(exp_rdata));
        chk("m_bclk",  64'(bus.o_bus_clk),  64'(exp_bclk));
        chk("m_we",    64'(bus.o_bus_we),   64'(exp_we));
        chk("m_addr",  64'(bus.o_bus_addr), 64'(exp_addr));
        chk("m_wdata", 64'(bus.o_bus_data), 64'(exp_wdata));
        chk("gnt_onehot0", 64'($countones(o_gnt) <= 1), 64'd1);
        if (i_rst) begin
            exp_done = '0;
            exp_err  = 0;
            if (!m_active) begin
                w = rr_first(i_req, m_ptr);
                if (w >= 0) begin
                    m_active  = 1;
                    m_win     = w;
                    m_age     = 0;
                    m_ptr     = (w + 1) % NUM_REQ;
                    exp_we    = i_we[w];
                    exp_addr  = i_addr[w*ADDR_W +: ADDR_W];
                    exp_wdata = i_wdata[w*DATA_W +: DATA_W];
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (bus.i_bus_data_ready) begin
                exp_done = NUM_REQ'(1) << m_win;
                if (!exp_we) exp_rdata = bus.i_bus_data;
                m_active = 0;
            end else if (TO_EN && m_age == TIMEOUT) begin
                exp_done  = NUM_REQ'(1) << m_win;
                exp_err   = 1;
                exp_rdata = '0;
                m_active  = 0;
            end else begin
                m_age++;
            end
            exp_gnt  = m_active ? (NUM_REQ'(1) << m_win) : '0;
            exp_busy = m_active;
            exp_bclk = m_active && (m_age == 0);
        end
    end

    // Wait (bounded) for the strobe cycle; returns at its negedge.
    task automatic wait_issue(input string nm);
        int n = 0;
        @(negedge i_clk);
        while (!bus.o_bus_clk && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk(nm, 64'(bus.o_bus_clk), 64'd1);
    endtask

    int grants[8];
    int ng;

    initial begin
        i_rst = 0; i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0;
        bus.i_bus_data = '0; bus.i_bus_data_ready = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_gnt",  64'(o_gnt), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_bclk", 64'(bus.o_bus_clk), 64'd0);
        step(); i_rst = 1;

        // single CPU read
        step(); i_req = 3'b001; i_we = '0; i_addr[0 +: ADDR_W] = 32'h100;
        @(negedge i_clk); chk("rd_n_bclk", 64'(bus.o_bus_clk), 64'd0);
        step(); @(negedge i_clk);
        chk("rd_n1_bclk", 64'(bus.o_bus_clk), 64'd1);
        chk("rd_n1_gnt",  64'(o_gnt), 64'd1);
        chk("rd_n1_addr", 64'(bus.o_bus_addr), 64'h100);
        step(); bus.i_bus_data_ready = 1; bus.i_bus_data = 32'hDEADBEEF;
        @(negedge i_clk);
        chk("rd_n2_bclk", 64'(bus.o_bus_clk), 64'd0);
        chk("rd_n2_done", 64'(o_done), 64'd0);
        step(); bus.i_bus_data_ready = 0; i_req = '0;
        @(negedge i_clk);
        chk("rd_n3_done",  64'(o_done), 64'd1);
        chk("rd_n3_rdata", 64'(o_rdata), 64'hDEADBEEF);
        chk("rd_n3_gnt",   64'(o_gnt), 64'd0);

        // contention from reset
        step(); i_rst = 0;
        step(); i_rst = 1; i_req = 3'b011; bus.i_bus_data_ready = 1; bus.i_bus_data = 32'h12345678;
        ng = 0;
        repeat (16) begin
            @(negedge i_clk);
            if (bus.o_bus_clk && ng < 8) begin
                grants[ng] = (o_gnt == 3'b001) ? 0 : (o_gnt == 3'b010) ? 1 : 9;
                ng++;
            end
            step();
        end
        chk("cont_g0", 64'(grants[0]), 64'd0);
        chk("cont_g1", 64'(grants[1]), 64'd1);
        chk("cont_g2", 64'(grants[2]), 64'd0);
        chk("cont_g3", 64'(grants[3]), 64'd1);
        i_req = '0;
        repeat (4) step();
        bus.i_bus_data_ready = 0;

        // write hold by requester 1
        step(); i_req = 3'b010; i_we = 3'b010;
        i_addr[ADDR_W +: ADDR_W] = 32'h1000; i_wdata[DATA_W +: DATA_W] = 32'h55;
        wait_issue("wr_issue");
        repeat (10) begin
            step(); @(negedge i_clk);
            chk("wr_hold_addr", 64'(bus.o_bus_addr), 64'h1000);
            chk("wr_hold_data", 64'(bus.o_bus_data), 64'h55);
            chk("wr_hold_we",   64'(bus.o_bus_we), 64'd1);
        end
        step(); bus.i_bus_data_ready = 1; bus.i_bus_data = 32'hBAD0BAD0;
        @(negedge i_clk); chk("wr_pre_done", 64'(o_done), 64'd0);
        step(); bus.i_bus_data_ready = 0; i_req = '0; i_we = '0;
        @(negedge i_clk);
        chk("wr_done",  64'(o_done), 64'b010);
        chk("wr_rdata", 64'(o_rdata), 64'h12345678);

        // reset in the middle of WAIT
        step(); i_req = 3'b001;
        wait_issue("rw_issue");
        step(); #2; i_rst = 0; #1;
        chk("rw_gnt",  64'(o_gnt), 64'd0);
        chk("rw_busy", 64'(o_busy), 64'd0);
        chk("rw_done", 64'(o_done), 64'd0);
        chk("rw_addr", 64'(bus.o_bus_addr), 64'd0);
        chk("rw_rdata", 64'(o_rdata), 64'd0);
        i_req = 3'b011;
        step(); step(); i_rst = 1;
        wait_issue("rw_reissue");
        chk("rw_ptr0_gnt", 64'(o_gnt), 64'b001);
        step(); bus.i_bus_data_ready = 1;
        step(); bus.i_bus_data_ready = 0; i_req = '0;
        step();

`ifdef CPU_BUS_ARB_TIMEOUT_EN
        // timeout with ready never asserted
        step(); i_req = 3'b001; bus.i_bus_data_ready = 0;
        wait_issue("to_issue");
        repeat (4) begin
            step(); @(negedge i_clk);
            chk("to_wait_done", 64'(o_done), 64'd0);
        end
        step(); @(negedge i_clk);
        chk("to_done",  64'(o_done), 64'd1);
        chk("to_err",   64'(o_err), 64'd1);
        chk("to_rdata", 64'(o_rdata), 64'd0);
        step(); @(negedge i_clk);
        chk("to_regrant", 64'(bus.o_bus_clk), 64'd1);
        // ready on the limit cycle
        repeat (4) step();
        bus.i_bus_data_ready = 1; bus.i_bus_data = 32'hCAFE0001;
        step(); bus.i_bus_data_ready = 0; i_req = '0;
        @(negedge i_clk);
        chk("lim_done",  64'(o_done), 64'd1);
        chk("lim_err",   64'(o_err), 64'd0);
        chk("lim_rdata", 64'(o_rdata), 64'hCAFE0001);
`endif

        // randomized traffic
        repeat (3000) begin
            step();
            for (int k = 0; k < NUM_REQ; k++) begin
                if (o_done[k]) begin
                    if ($urandom % 2 == 0) i_req[k] = 1'b0;
                end else if (!i_req[k]) begin
                    if ($urandom % 3 == 0) begin
                        i_req[k] = 1'b1;
                        i_we[k]  = 1'($urandom % 2);
                        i_addr[k*ADDR_W +: ADDR_W]  = $urandom;
                        i_wdata[k*DATA_W +: DATA_W] = $urandom;
                    end
                end else if (o_gnt[k] && ($urandom % 20 == 0)) begin
                    i_req[k] = 1'b0;
                end
            end
            bus.i_bus_data_ready = ($urandom % 5 == 0);
            bus.i_bus_data       = $urandom;
        end
        step();
        @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Round-robin arbiter that shares the CPU's single external memory bus (`o_bus_clk`/`o_bus_we`/`o_bus_addr`/`o_bus_data`, completed by `i_bus_data_ready`) between several requesters: the CPU core, a DMA engine, and the video fetcher. It sits between those masters and the bus fabric. It serialises one transfer at a time and returns read data and a per-requester completion pulse.

## Interface
- `NUM_REQ`, 2: number of requesters, from 2 to 8; index 0 is the CPU.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: maximum WAIT cycles before abort. Used only when `CPU_BUS_ARB_TIMEOUT_EN` is defined.

Ports:
- `i_clk`  in  1  sole clock; all logic on rising edge.
- `i_rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  NUM_REQ  per-requester request level.
- `i_we`  in  NUM_REQ  per-requester write flag.
- `i_addr`  in  NUM_REQ*ADDR_W  packed addresses; slice k belongs to requester k.
- `i_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `o_gnt`  out  NUM_REQ  one-hot grant, held for the whole transfer.
- `o_done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `o_rdata`  out  DATA_W  shared read data; valid in the `o_done` cycle.
- `o_err`  out  1  abort pulse, coincident with `o_done`.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_bus_clk`  out  1  one-cycle transfer strobe.
- `o_bus_we`, `o_bus_addr`, `o_bus_data`  out  1/ADDR_W/DATA_W  transfer attributes.
- `i_bus_data`  in  DATA_W  read data from the fabric.
- `i_bus_data_ready`  in  1  transfer complete.

## Operation
States: IDLE, ISSUE, WAIT.

- **Reset** (`i_rst`=0, async):
  - State goes to IDLE and the round-robin pointer goes to 0.
  - All outputs go to 0: `o_gnt`, `o_done`, `o_rdata`, `o_err`, `o_busy`, `o_bus_*`.
  - Reset mid-transfer abandons the transfer with no `o_done`.
- **IDLE**:
  - With any `i_req` bit set, pick the first set bit scanning upward from the pointer, wrapping modulo NUM_REQ.
  - Register the grant and latch that requester's we/addr/wdata onto `o_bus_we`/`o_bus_addr`/`o_bus_data`. Go to ISSUE.
  - Pointer becomes winner+1 (mod NUM_REQ).
  - With no requests: stay in IDLE; pointer unchanged.
- **ISSUE**:
  - `o_bus_clk`=1 for exactly this cycle; always go to WAIT.
  - `i_bus_data_ready` is ignored in ISSUE.
- **WAIT**:
  - `o_bus_*` attributes are held stable.
  - On `i_bus_data_ready`=1, the next cycle has:
    - `o_done[winner]`=1 and `o_gnt`=0.
    - `o_rdata` = `i_bus_data` for reads; `o_rdata` unchanged for writes.
    - State IDLE.
- **Requester rules**:
  - Hold `i_req` and attributes stable until `o_done`.
  - Dropping `i_req` mid-transfer does not abort the transfer.
  - `i_req` still high on the cycle after `o_done` counts as a new request, arbitrated fairly.
- **Simultaneous requests**: the pointer guarantees no requester waits more than NUM_REQ-1 transfers.

## Timing
- Request seen in IDLE at cycle N:
  - N+1: ISSUE, with `o_gnt`, `o_bus_clk`, `o_bus_*` valid.
  - N+2: first WAIT cycle.
- Ready at cycle M in WAIT gives `o_done` at M+1.
- Back-to-back transfers: next grant at M+2, so minimum 3 cycles per transfer plus fabric wait.
- `o_done` and `o_err` are single-cycle pulses. `o_rdata` holds until the next read completes.

## Configuration
- `CPU_BUS_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT-1 without ready, the next cycle pulses `o_done[winner]` and `o_err`, with `o_rdata`=0, and returns to IDLE.
  - Ready arriving on the same cycle as the limit counts as normal completion; `o_err`=0.
- Not defined: WAIT blocks indefinitely, no counter is built, and `o_err` is tied 0.

## Structure
- Package `cpu_bus_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT);
  - the default width constants;
  - the timeout counter width.
- Sub-module `rr_pick`: combinational priority selector.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner, winner index, any-valid.
- The top level holds the FSM, attribute latches, pointer and timeout counter.

## Test plan
- Single CPU read: req[0] at N, ready at N+2 with data 0xDEADBEEF → `o_bus_clk` high only at N+1, `o_done[0]` at N+3, `o_rdata`=0xDEADBEEF.
- Contention: req=2'b11 held continuously from reset → grants alternate 0,1,0,1; `o_gnt` never has two bits set.
- Write hold: requester 1 writes addr 0x1000, data 0x55, ready delayed 10 cycles → `o_bus_addr`/`o_bus_data`/`o_bus_we` stable for all 10 cycles; `o_rdata` unchanged.
- Reset mid-WAIT: `i_rst` low during WAIT → all outputs 0 immediately; no `o_done`; the next request is arbitrated from pointer 0.
- Timeout (macro on, TIMEOUT=4): ready never asserted → `o_done[winner]`+`o_err` 5 cycles after ISSUE, `o_rdata`=0, then a new grant is possible.
- Ready on the limit cycle (macro on) → `o_done`=1, `o_err`=0, data captured.
